// File: rtl/quad_step_decoder_pkg.sv
// Shared quadrature encoding for the step decoder and anything that models it.
// The {A,B} pair walks Q00 -> Q10 -> Q11 -> Q01 -> Q00 when moving up.
package quad_step_decoder_pkg;

    typedef logic [1:0] quad_t;

    localparam quad_t Q00 = 2'b00;
    localparam quad_t Q10 = 2'b10;
    localparam quad_t Q11 = 2'b11;
    localparam quad_t Q01 = 2'b01;

    function automatic quad_t next_up(input quad_t cur);
        case (cur)
            Q00:     next_up = Q10;
            Q10:     next_up = Q11;
            Q11:     next_up = Q01;
            default: next_up = Q00;
        endcase
    endfunction

    function automatic quad_t next_down(input quad_t cur);
        case (cur)
            Q00:     next_down = Q01;
            Q01:     next_down = Q11;
            Q11:     next_down = Q10;
            default: next_down = Q00;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_decoder_sync_filter.sv
// Two-flop synchroniser for the A/B pair plus a saturating stability counter.
// 'accept' pulses for one cycle whenever 'stable' is loaded with a value that held long enough.
module sync_filter
    import quad_step_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int FCNT_W        = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  qa,
    input  logic  qb,
    output quad_t stable,
    output logic  accept
);

    localparam logic [FCNT_W:0]   RUN_TARGET = (FCNT_W + 1)'(FILTER_CYCLES);
    localparam logic [FCNT_W-1:0] CNT_MAX    = '1;

    quad_t             sync1;
    quad_t             sync2;
    logic [1:0]        fill;
    quad_t             cand;
    logic [FCNT_W-1:0] cnt;
    logic [FCNT_W:0]   run;

    // Run length of sync2 including the current edge; one bit wider so saturation never aliases the target.
    always_comb begin
        run = (FCNT_W + 1)'(1);
        if (sync2 == cand) begin
            run = {1'b0, cnt} + (FCNT_W + 1)'(1);
        end
    end

    // NOTE: every register here is assigned with <= so all flops sample the pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= Q00;
            sync2  <= Q00;
            fill   <= 2'b00;
            cand   <= Q00;
            cnt    <= '0;
            stable <= Q00;
            accept <= 1'b0;
        end else begin
            sync1  <= {qa, qb};
            sync2  <= sync1;
            fill   <= {fill[0], 1'b1};
            accept <= 1'b0;
            // sync2 still holds reset zeros until the chain has refilled; ignore it until then.
            if (fill[1]) begin
                cand <= sync2;
                cnt  <= (run > {1'b0, CNT_MAX}) ? CNT_MAX : run[FCNT_W-1:0];
                if (run == RUN_TARGET) begin
                    stable <= sync2;
                    accept <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to enable/upDown step converter with illegal-transition flag.
// The first filtered value after reset only primes the previous-position register.
module quad_step_decoder
    import quad_step_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int FCNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic qa,
    input  logic qb,
    output logic enable,
    output logic upDown,
    output logic err
);

    quad_t stable;
    logic  accept;

    quad_t prev_q,   prev_d;
    logic  primed_q, primed_d;
    logic  enable_q, enable_d;
    logic  err_q,    err_d;
    logic  up_q,     up_d;

    sync_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .FCNT_W        (FCNT_W)
    ) u_sync_filter (
        .clk    (clk),
        .rst    (rst),
        .qa     (qa),
        .qb     (qb),
        .stable (stable),
        .accept (accept)
    );

    // NOTE: all outputs of this block get a default first, so no path can infer a latch.
    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        enable_d = 1'b0;
        err_d    = 1'b0;
        up_d     = up_q;
        if (accept) begin
            prev_d = stable;
            if (!primed_q) begin
                primed_d = 1'b1;
            end else if (stable == next_up(prev_q)) begin
                enable_d = 1'b1;
                up_d     = 1'b1;
            end else if (stable == next_down(prev_q)) begin
                enable_d = 1'b1;
                up_d     = 1'b0;
            end else if (stable != prev_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= Q00;
            primed_q <= 1'b0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            up_q     <= 1'b1;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            enable_q <= enable_d;
            err_q    <= err_d;
            up_q     <= up_d;
        end
    end

    assign enable = enable_q;
    assign err    = err_q;
    assign upDown = up_q;

endmodule
